// File: rtl/hall_pkg.sv
// Shared types and constant helpers for the hall sector tracker: state encoding,
// hall code decode over the sector sequence table, and sector lower-bound angles.
package hall_pkg;

    localparam int unsigned HALL_W  = 3;
    localparam int unsigned SECT_W  = 3;
    localparam int unsigned SECTORS = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [SECT_W-1:0] sector;
    } hall_dec_t;

    // Codes 0/7 and codes missing from the table are invalid; first table hit wins.
    function automatic hall_dec_t hall_decode(input logic [HALL_W-1:0] code,
                                              input logic [23:0] seq);
        hall_dec_t d;
        d = '0;
        if (code != 3'd0 && code != 3'd7) begin
            for (int k = 0; k < int'(SECTORS); k++) begin
                if (!d.valid && seq[4*k +: 4] == {1'b0, code}) begin
                    d.valid  = 1'b1;
                    d.sector = SECT_W'(k);
                end
            end
        end
        return d;
    endfunction

    // Lower window bound of a sector; only ever evaluated on constants.
    function automatic logic [63:0] sector_lo(input logic [63:0] sector,
                                              input logic [63:0] ofs,
                                              input logic [63:0] full);
        logic [63:0] lo;
        lo = ofs + sector * (full / 64'(SECTORS));
        if (lo >= full)
            lo = lo - full;
        return lo;
    endfunction

endpackage

// File: rtl/hall_sector_tracker_debounce.sv
// Hall code debouncer: a code is accepted once it has been sampled unchanged
// for DEBOUNCE consecutive cycles; accept_c marks the accepting edge.
module hall_debounce
    import hall_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [HALL_W-1:0] hall,
    output logic [HALL_W-1:0] code_c,
    output logic              accept_c
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEBOUNCE);

    logic [HALL_W-1:0] cand;
    logic [CNT_W-1:0]  cnt;
    logic              changed;

    assign changed  = (hall != cand);
    assign code_c   = hall;
    // Counter saturates at DEBOUNCE so a held code is accepted exactly once.
    assign accept_c = changed ? (DEBOUNCE == 1) : (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand <= '0;
            cnt  <= '0;
        end else if (changed) begin
            cand <= hall;
            cnt  <= CNT_W'(1);
        end else if (cnt != CNT_FULL) begin
            cnt  <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hall_sector_tracker.sv
// Hall sector tracker: debounced hall decode, sector/direction/period tracking,
// fault handling, DAC code and rotor-angle clamping to the current sector window.
module hall_sector_tracker
    import hall_pkg::*;
#(
    parameter int unsigned ANGLE_W    = 32,
    parameter int unsigned ANGLE_FULL = 3600000,
    parameter int unsigned ANGLE_OFS  = 3300000,
    parameter logic [23:0] HALL_SEQ   = 24'h623154,
    parameter int unsigned DEBOUNCE   = 4,
    parameter int unsigned PERIOD_W   = 24,
    parameter int unsigned DAC_SCALE  = 500,
    parameter int unsigned DAC_W      = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [HALL_W-1:0]   hall,
    input  logic [ANGLE_W-1:0]  angle_in,
    input  logic                angle_vld,
    output logic [ANGLE_W-1:0]  angle_o,
    output logic                angle_o_vld,
    output logic [SECT_W-1:0]   sector_o,
    output logic                dir_o,
    output logic [PERIOD_W-1:0] period_o,
    output logic                period_vld,
    output logic                stall_o,
    output logic                fault_o,
    output logic                skip_o,
    output logic [DAC_W-1:0]    dac_o
);

    localparam int unsigned AXW = ANGLE_W + 1;
    localparam logic [ANGLE_W:0] FULL_X = AXW'(ANGLE_FULL);
    localparam logic [ANGLE_W:0] SECT_X = AXW'(ANGLE_FULL / SECTORS);
    localparam logic [ANGLE_W:0] HALF_X =
        AXW'((64'(ANGLE_FULL) + 64'(ANGLE_FULL / SECTORS)) / 64'd2);
    localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

    logic [HALL_W-1:0] code_c;
    logic              accept_c;
    hall_dec_t         dec;

    hall_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .hall     (hall),
        .code_c   (code_c),
        .accept_c (accept_c)
    );

    assign dec = hall_decode(code_c, HALL_SEQ);

    // Constant table of sector lower bounds; entries 6/7 are unreachable.
    logic [ANGLE_W:0] lo_tab [8];
    for (genvar s = 0; s < 8; s++) begin : g_lo
        localparam logic [ANGLE_W:0] LO = (s < SECTORS) ?
            AXW'(sector_lo(64'(s), 64'(ANGLE_OFS), 64'(ANGLE_FULL))) : '0;
        assign lo_tab[s] = LO;
    end

    logic [ANGLE_W:0]   lo_c, hi_c, rel_c;
    logic [ANGLE_W-1:0] clamp_c;

    // Window clamp against the sector held before this edge.
    always_comb begin
        lo_c = lo_tab[sector_o];
        hi_c = lo_c + SECT_X;
        if (hi_c >= FULL_X)
            hi_c = hi_c - FULL_X;
        rel_c = {1'b0, angle_in} - lo_c;
        if (rel_c[ANGLE_W])
            rel_c = rel_c + FULL_X;
        if (rel_c <= SECT_X)
            clamp_c = angle_in;
        else if (rel_c < HALF_X)
            clamp_c = hi_c[ANGLE_W-1:0];
        else
            clamp_c = lo_c[ANGLE_W-1:0];
    end

    state_t              state, state_n;
    logic [PERIOD_W-1:0] cnt, cnt_n;
    logic [SECT_W-1:0]   sector_n, delta_c;
    logic [ANGLE_W-1:0]  angle_n;
    logic [PERIOD_W-1:0] period_n;
    logic [DAC_W-1:0]    dac_n;
    logic                dir_n, stall_n, skip_n, period_vld_n, angle_vld_n, fault_n;

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        sector_n     = sector_o;
        dir_n        = dir_o;
        period_n     = period_o;
        period_vld_n = 1'b0;
        stall_n      = stall_o;
        skip_n       = 1'b0;
        dac_n        = dac_o;
        angle_n      = angle_o;
        angle_vld_n  = 1'b0;
        delta_c      = (dec.sector >= sector_o) ? SECT_W'(dec.sector - sector_o)
                                                : SECT_W'(dec.sector + 3'd6 - sector_o);

        if (state == ST_LOCKED) begin
            if (cnt != CNT_MAX)
                cnt_n = cnt + PERIOD_W'(1);
            if (cnt_n == CNT_MAX)
                stall_n = 1'b1;
        end

        if (accept_c) begin
            if (!dec.valid) begin
                state_n = ST_FAULT;
            end else begin
                dac_n = DAC_W'(DAC_W'(code_c) * DAC_W'(DAC_SCALE));
                if (state == ST_LOCKED) begin
                    if (dec.sector != sector_o) begin
                        sector_n     = dec.sector;
                        period_n     = cnt;
                        period_vld_n = 1'b1;
                        cnt_n        = PERIOD_W'(1);
                        stall_n      = 1'b0;
                        if (delta_c == 3'd1)
                            dir_n = 1'b1;
                        else if (delta_c == 3'd5)
                            dir_n = 1'b0;
                        else
                            skip_n = 1'b1;
                    end
                end else begin
                    state_n  = ST_LOCKED;
                    sector_n = dec.sector;
                    cnt_n    = '0;
                    stall_n  = 1'b0;
                end
            end
        end

        if (angle_vld && state == ST_LOCKED) begin
            angle_n     = clamp_c;
            angle_vld_n = 1'b1;
        end

        fault_n = (state_n == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            sector_o    <= '0;
            dir_o       <= 1'b0;
            period_o    <= '0;
            period_vld  <= 1'b0;
            stall_o     <= 1'b0;
            skip_o      <= 1'b0;
            fault_o     <= 1'b0;
            dac_o       <= '0;
            angle_o     <= '0;
            angle_o_vld <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            sector_o    <= sector_n;
            dir_o       <= dir_n;
            period_o    <= period_n;
            period_vld  <= period_vld_n;
            stall_o     <= stall_n;
            skip_o      <= skip_n;
            fault_o     <= fault_n;
            dac_o       <= dac_n;
            angle_o     <= angle_n;
            angle_o_vld <= angle_vld_n;
        end
    end

endmodule

// File: tb/tb_hall_sector_tracker.sv
// Directed bench for hall_sector_tracker: clamp vector table plus hand sequences
// for debounce, direction, skip, fault, reset and period saturation.
module tb_hall_sector_tracker;

    logic        clk = 1'b0;
    logic        rst_n, angle_vld;
    logic [2:0]  hall;
    logic [31:0] angle_in;
    logic [31:0] angle_o;
    logic        angle_o_vld, dir_o, period_vld, stall_o, fault_o, skip_o;
    logic [2:0]  sector_o;
    logic [23:0] period_o;
    logic [31:0] dac_o;

    logic        rst2_n, angle_vld2;
    logic [2:0]  hall2;
    logic [31:0] angle_in2;
    logic [31:0] angle_o2;
    logic        angle_o_vld2, dir2, period_vld2, stall2, fault2, skip2;
    logic [2:0]  sector2;
    logic [3:0]  period2;
    logic [31:0] dac2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0, t1;
    logic [31:0] last_angle;
    logic        glitch_bad;

    always #5 clk = ~clk;

    hall_sector_tracker dut (
        .clk(clk), .rst_n(rst_n), .hall(hall), .angle_in(angle_in), .angle_vld(angle_vld),
        .angle_o(angle_o), .angle_o_vld(angle_o_vld), .sector_o(sector_o), .dir_o(dir_o),
        .period_o(period_o), .period_vld(period_vld), .stall_o(stall_o), .fault_o(fault_o),
        .skip_o(skip_o), .dac_o(dac_o)
    );

    hall_sector_tracker #(.PERIOD_W(4)) dut2 (
        .clk(clk), .rst_n(rst2_n), .hall(hall2), .angle_in(angle_in2), .angle_vld(angle_vld2),
        .angle_o(angle_o2), .angle_o_vld(angle_o_vld2), .sector_o(sector2), .dir_o(dir2),
        .period_o(period2), .period_vld(period_vld2), .stall_o(stall2), .fault_o(fault2),
        .skip_o(skip2), .dac_o(dac2)
    );

    typedef struct {
        logic [31:0] angle;
        logic [31:0] exp;
    } clamp_vec_t;

    clamp_vec_t vt [12];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_angle_o"}, 64'(angle_o), 0);
        chk({tag, "_angle_o_vld"}, 64'(angle_o_vld), 0);
        chk({tag, "_sector_o"}, 64'(sector_o), 0);
        chk({tag, "_dir_o"}, 64'(dir_o), 0);
        chk({tag, "_period_o"}, 64'(period_o), 0);
        chk({tag, "_period_vld"}, 64'(period_vld), 0);
        chk({tag, "_stall_o"}, 64'(stall_o), 0);
        chk({tag, "_fault_o"}, 64'(fault_o), 0);
        chk({tag, "_skip_o"}, 64'(skip_o), 0);
        chk({tag, "_dac_o"}, 64'(dac_o), 0);
    endtask

    task automatic clamp_check(input string name, input logic [31:0] a, input logic [31:0] e);
        angle_in  = a;
        angle_vld = 1'b1;
        step();
        angle_vld = 1'b0;
        chk({name, "_vld"}, 64'(angle_o_vld), 1);
        chk(name, 64'(angle_o), 64'(e));
        last_angle = e;
    endtask

    initial begin
        // Sector 0 window: lo=3300000, hi=300000 (wrapped), clamp midpoint rel=2100000.
        vt[0]  = '{32'd1000000, 32'd300000};
        vt[1]  = '{32'd2500000, 32'd3300000};
        vt[2]  = '{32'd100000,  32'd100000};
        vt[3]  = '{32'd3300000, 32'd3300000};
        vt[4]  = '{32'd300000,  32'd300000};
        vt[5]  = '{32'd300001,  32'd300000};
        vt[6]  = '{32'd3599999, 32'd3599999};
        vt[7]  = '{32'd0,       32'd0};
        vt[8]  = '{32'd1799999, 32'd300000};
        vt[9]  = '{32'd1800000, 32'd3300000};
        vt[10] = '{32'd3299999, 32'd3300000};
        vt[11] = '{32'd1500000, 32'd300000};

        rst_n = 1'b0; hall = 3'd4; angle_in = '0; angle_vld = 1'b0;
        rst2_n = 1'b0; hall2 = 3'd4; angle_in2 = '0; angle_vld2 = 1'b0;
        last_angle = '0;
        step(); step();
        chk_zero("rst");

        // Acquisition: angle strobes in IDLE, including the accepting edge, are dropped.
        rst_n = 1'b1; angle_vld = 1'b1; angle_in = 32'd1000000;
        repeat (3) step();
        chk("pre_accept_dac", 64'(dac_o), 0);
        chk("idle_no_strobe", 64'(angle_o_vld), 0);
        step();
        t0 = cyc;
        chk("accept_sector", 64'(sector_o), 0);
        chk("accept_dac", 64'(dac_o), 2000);
        chk("accept_no_period_vld", 64'(period_vld), 0);
        chk("accept_edge_no_strobe", 64'(angle_o_vld), 0);
        chk("accept_fault", 64'(fault_o), 0);
        angle_vld = 1'b0;

        for (int i = 0; i < 12; i++)
            clamp_check($sformatf("clamp_s0_%0d", i), vt[i].angle, vt[i].exp);
        step();
        chk("strobe_one_cycle", 64'(angle_o_vld), 0);

        // Forward step 4->5 with the accepting edge 1000 cycles after entry.
        while (cyc - t0 < 996) step();
        hall = 3'd5;
        repeat (4) step();
        chk("fwd_period", 64'(period_o), 64'(cyc - t0 - 1));
        chk("fwd_period_vld", 64'(period_vld), 1);
        chk("fwd_dir", 64'(dir_o), 1);
        chk("fwd_sector", 64'(sector_o), 1);
        chk("fwd_skip", 64'(skip_o), 0);
        chk("fwd_dac", 64'(dac_o), 2500);
        t1 = cyc;
        step();
        chk("period_vld_pulse", 64'(period_vld), 0);

        clamp_check("clamp_s1_in", 32'd600000, 32'd600000);
        clamp_check("clamp_s1_hi", 32'd1000000, 32'd900000);
        clamp_check("clamp_s1_lo", 32'd3000000, 32'd300000);

        // Reverse step 5->4.
        repeat (20) step();
        hall = 3'd4;
        repeat (4) step();
        chk("rev_period", 64'(period_o), 64'(cyc - t1));
        chk("rev_dir", 64'(dir_o), 0);
        chk("rev_sector", 64'(sector_o), 0);
        chk("rev_period_vld", 64'(period_vld), 1);

        // Non-adjacent jumps 0->4 and 4->0 keep direction.
        hall = 3'd2;
        repeat (4) step();
        chk("skip_sector", 64'(sector_o), 4);
        chk("skip_pulse", 64'(skip_o), 1);
        chk("skip_dir", 64'(dir_o), 0);
        step();
        chk("skip_one_cycle", 64'(skip_o), 0);
        hall = 3'd4;
        repeat (4) step();
        chk("skip_back_sector", 64'(sector_o), 0);
        chk("skip_back_pulse", 64'(skip_o), 1);

        // Three-cycle glitch must not disturb anything.
        glitch_bad = 1'b0;
        hall = 3'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (sector_o != 3'd0 || period_vld || fault_o) glitch_bad = 1'b1;
        end
        hall = 3'd4;
        for (int i = 0; i < 8; i++) begin
            step();
            if (sector_o != 3'd0 || period_vld || fault_o || skip_o) glitch_bad = 1'b1;
        end
        chk("glitch_ignored", 64'(glitch_bad), 0);
        chk("glitch_dac", 64'(dac_o), 2000);

        // Invalid code 7 -> FAULT; outputs held, strobe suppressed.
        hall = 3'd7;
        repeat (3) step();
        chk("fault_not_yet", 64'(fault_o), 0);
        step();
        chk("fault_set", 64'(fault_o), 1);
        angle_in = 32'd1000000; angle_vld = 1'b1;
        step();
        angle_vld = 1'b0;
        chk("fault_no_strobe", 64'(angle_o_vld), 0);
        chk("fault_angle_held", 64'(angle_o), 64'(last_angle));
        chk("fault_sector_held", 64'(sector_o), 0);
        hall = 3'd4;
        repeat (4) step();
        chk("recover_fault", 64'(fault_o), 0);
        chk("recover_sector", 64'(sector_o), 0);
        chk("recover_no_period_vld", 64'(period_vld), 0);
        chk("recover_dac", 64'(dac_o), 2000);
        clamp_check("clamp_relock", 32'd100000, 32'd100000);

        // Reset in mid-operation with a concurrent angle strobe.
        hall = 3'd5; angle_in = 32'd2500000; angle_vld = 1'b1; rst_n = 1'b0;
        step();
        chk_zero("midrst");
        rst_n = 1'b1; angle_vld = 1'b0;
        repeat (3) step();
        chk("midrst_debounce_restart", 64'(dac_o), 0);
        step();
        chk("midrst_reaccept_dac", 64'(dac_o), 2500);
        chk("midrst_reaccept_sector", 64'(sector_o), 1);

        // 4-bit period counter saturates at 15 and sets stall.
        rst2_n = 1'b1;
        repeat (4) step();
        chk("sat_accept_sector", 64'(sector2), 0);
        repeat (14) step();
        chk("sat_stall_before", 64'(stall2), 0);
        step();
        chk("sat_stall_set", 64'(stall2), 1);
        repeat (5) step();
        chk("sat_stall_held", 64'(stall2), 1);
        hall2 = 3'd5;
        repeat (4) step();
        chk("sat_period", 64'(period2), 15);
        chk("sat_period_vld", 64'(period_vld2), 1);
        chk("sat_stall_clear", 64'(stall2), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
